en_sequencer: RTL



---
 rtl/en_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/en_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | en_sequencer: repeating on/off clock-enable pattern for a BUFGCE CE pin.  |
// | Option: EN_SEQ_CMD_SYNC_EN synchronizes start/stop as async levels.       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module en_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk100m,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] on_cycles,
  input  logic [CNT_W-1:0] off_cycles,
  input  logic [CNT_W-1:0] num_periods,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period_cnt
);

  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_zero = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_on_len, r_off_len, r_num, r_phase, r_period_cnt;
  logic [CNT_W-1:0] w_on_nxt, w_off_nxt, w_num_nxt, w_phase_nxt, w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_en, r_busy, r_done, w_done_nxt;
  logic             w_start, w_stop;

`ifdef EN_SEQ_CMD_SYNC_EN
  // Two synchronizer flops plus a third for rising-edge detection.
  logic [2:0] r_start_sync, r_stop_sync;

  always_ff @(posedge clk100m or posedge rst) begin
    if (rst) begin
      r_start_sync <= 3'b000;
      r_stop_sync  <= 3'b000;
    end else begin
      r_start_sync <= {r_start_sync[1:0], start};
      r_stop_sync  <= {r_stop_sync[1:0], stop};
    end
  end

  assign w_start = r_start_sync[1] & ~r_start_sync[2];
  assign w_stop  = r_stop_sync[1] & ~r_stop_sync[2];
`else
  assign w_start = start;
  assign w_stop  = stop;
`endif

  assign w_cnt_inc = r_period_cnt + c_one;

  always_comb begin
    w_state_nxt = r_state;
    w_on_nxt    = r_on_len;
    w_off_nxt   = r_off_len;
    w_num_nxt   = r_num;
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_period_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start && !w_stop) begin
          w_on_nxt    = (on_cycles == c_zero) ? c_one : on_cycles;
          w_off_nxt   = (off_cycles == c_zero) ? c_one : off_cycles;
          w_num_nxt   = num_periods;
          w_phase_nxt = c_zero;
          w_cnt_nxt   = c_zero;
          w_state_nxt = ST_ON;
        end
      end
      ST_ON: begin
        if (w_stop) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_phase == r_on_len - c_one) begin
          w_phase_nxt = c_zero;
          w_state_nxt = ST_OFF;
        end else begin
          w_phase_nxt = r_phase + c_one;
        end
      end
      ST_OFF: begin
        // A period that completes on the stop cycle still counts.
        if (r_phase == r_off_len - c_one) begin
          w_phase_nxt = c_zero;
          w_cnt_nxt   = w_cnt_inc;
          if (w_stop || (r_num != c_zero && w_cnt_inc == r_num)) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_ON;
          end
        end else if (w_stop) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_phase_nxt = r_phase + c_one;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk100m or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_on_len     <= c_one;
      r_off_len    <= c_one;
      r_num        <= c_zero;
      r_phase      <= c_zero;
      r_period_cnt <= c_zero;
      r_en         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_on_len     <= w_on_nxt;
      r_off_len    <= w_off_nxt;
      r_num        <= w_num_nxt;
      r_phase      <= w_phase_nxt;
      r_period_cnt <= w_cnt_nxt;
      r_en         <= (w_state_nxt == ST_ON);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_done       <= w_done_nxt;
    end
  end

  assign en         = r_en;
  assign busy       = r_busy;
  assign done       = r_done;
  assign period_cnt = r_period_cnt;

endmodule
`default_nettype wire
